// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, taken-branch flush window, memory-busy freeze and EX forwarding selects.
// Define PERF_CNT_EN to build the stall/flush performance counters; otherwise both read as zero.

module hazard_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       Rn_d,
   input  logic [4:0]       Rm_d,
   input  logic             usesRn_d,
   input  logic             usesRm_d,
   input  logic [4:0]       Rn_x,
   input  logic [4:0]       Rm_x,
   input  logic [4:0]       destreg_x,
   input  logic             MemRead_x,
   input  logic [4:0]       destreg_m,
   input  logic             RegWrite_m,
   input  logic [4:0]       destreg_w,
   input  logic             RegWrite_w,
   input  logic             br_taken_m,
   input  logic             mem_busy,
   output logic             pc_en,
   output logic             ifde_en,
   output logic             ifde_flush,
   output logic             idex_bubble,
   output logic             exmem_flush,
   output logic             all_hold,
   output logic [1:0]       fwdA,
   output logic [1:0]       fwdB,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   // state    | meaning
   // ST_RUN   | normal issue; load-use stalls and taken branches are acted on here
   // ST_FLUSH | IF/ID squashed for r_flush_left more cycles after a taken branch

   localparam logic [4:0] XZR        = 5'd31;
   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   state_t     r_state;
   logic [3:0] r_flush_left;

   logic w_lu_rn;
   logic w_lu_rm;
   logic w_lu;
   logic w_in_run;
   logic w_br_start;
   logic w_lu_stall;
   logic w_a_m;
   logic w_a_w;
   logic w_b_m;
   logic w_b_w;

   assign w_lu_rn    = usesRn_d && (Rn_d == destreg_x);
   assign w_lu_rm    = usesRm_d && (Rm_d == destreg_x);
   assign w_lu       = MemRead_x && (destreg_x != XZR) && (w_lu_rn || w_lu_rm);

   assign w_in_run   = (r_state == ST_RUN);
   assign w_br_start = !mem_busy && w_in_run && br_taken_m;
   assign w_lu_stall = !mem_busy && w_in_run && !br_taken_m && w_lu;

   // XZR is never a real producer, so a write to it must not be forwarded
   assign w_a_m = RegWrite_m && (destreg_m != XZR) && (destreg_m == Rn_x);
   assign w_a_w = RegWrite_w && (destreg_w != XZR) && (destreg_w == Rn_x);
   assign w_b_m = RegWrite_m && (destreg_m != XZR) && (destreg_m == Rm_x);
   assign w_b_w = RegWrite_w && (destreg_w != XZR) && (destreg_w == Rm_x);

   always_comb begin
      fwdA = 2'b00;
      fwdB = 2'b00;
      if (!reset) begin
         if (w_a_m)      fwdA = 2'b01;
         else if (w_a_w) fwdA = 2'b10;
         if (w_b_m)      fwdB = 2'b01;
         else if (w_b_w) fwdB = 2'b10;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_RUN;
         r_flush_left <= 4'd0;
      end else if (!mem_busy) begin
         case (r_state)
            ST_RUN: begin
               if (br_taken_m) begin
                  r_state      <= ST_FLUSH;
                  r_flush_left <= FLUSH_LOAD;
               end
            end
            ST_FLUSH: begin
               r_flush_left <= r_flush_left - 4'd1;
               if (r_flush_left <= 4'd1) begin
                  r_state      <= ST_RUN;
                  r_flush_left <= 4'd0;
               end
            end
            default: begin
               r_state      <= ST_RUN;
               r_flush_left <= 4'd0;
            end
         endcase
      end
   end

   // Decoded from state plus this cycle's inputs so a freeze or flush takes effect in the same cycle
   always_comb begin
      pc_en       = 1'b1;
      ifde_en     = 1'b1;
      ifde_flush  = 1'b0;
      idex_bubble = 1'b0;
      exmem_flush = 1'b0;
      all_hold    = 1'b0;
      if (!reset) begin
         if (mem_busy) begin
            all_hold = 1'b1;
            pc_en    = 1'b0;
            ifde_en  = 1'b0;
         end else if (w_br_start) begin
            ifde_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
         end else if (w_lu_stall) begin
            pc_en       = 1'b0;
            ifde_en     = 1'b0;
            idex_bubble = 1'b1;
         end else if (r_state == ST_FLUSH) begin
            ifde_flush = 1'b1;
         end
      end
   end

`ifdef PERF_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;
   logic             w_stall_inc;

   assign w_stall_inc = mem_busy || w_lu_stall;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall_inc && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_br_start && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (FLUSH_CYCLES=2, CNT_W=4).
// Counter expectations follow PERF_CNT_EN: tracked counts when defined, zero otherwise.

module tb_hazard_ctrl;

   localparam int CW = 4;
`ifdef PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // {pc_en, ifde_en, ifde_flush, idex_bubble, exmem_flush, all_hold}
   localparam logic [5:0] V_RUN   = 6'b110000;
   localparam logic [5:0] V_STALL = 6'b000100;
   localparam logic [5:0] V_BR    = 6'b111110;
   localparam logic [5:0] V_FL    = 6'b111000;
   localparam logic [5:0] V_HOLD  = 6'b000001;

   logic          clk = 1'b0;
   logic          reset;
   logic [4:0]    Rn_d, Rm_d, Rn_x, Rm_x, destreg_x, destreg_m, destreg_w;
   logic          usesRn_d, usesRm_d, MemRead_x, RegWrite_m, RegWrite_w;
   logic          br_taken_m, mem_busy;
   logic          pc_en, ifde_en, ifde_flush, idex_bubble, exmem_flush, all_hold;
   logic [1:0]    fwdA, fwdB;
   logic [CW-1:0] stall_cnt, flush_cnt;
   logic [5:0]    ctl;

   int tests_run = 0;
   int tests_failed = 0;
   int e_stall = 0;
   int e_flush = 0;

   assign ctl = {pc_en, ifde_en, ifde_flush, idex_bubble, exmem_flush, all_hold};

   always #5 clk = ~clk;

   hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .Rn_d(Rn_d), .Rm_d(Rm_d), .usesRn_d(usesRn_d), .usesRm_d(usesRm_d),
      .Rn_x(Rn_x), .Rm_x(Rm_x), .destreg_x(destreg_x), .MemRead_x(MemRead_x),
      .destreg_m(destreg_m), .RegWrite_m(RegWrite_m),
      .destreg_w(destreg_w), .RegWrite_w(RegWrite_w),
      .br_taken_m(br_taken_m), .mem_busy(mem_busy),
      .pc_en(pc_en), .ifde_en(ifde_en), .ifde_flush(ifde_flush),
      .idex_bubble(idex_bubble), .exmem_flush(exmem_flush), .all_hold(all_hold),
      .fwdA(fwdA), .fwdB(fwdB), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   function automatic logic [CW-1:0] cexp(input int n);
      if (!PERF) return '0;
      if (n >= (1 << CW) - 1) return '1;
      return CW'(n);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      Rn_d = 5'd0; Rm_d = 5'd0; usesRn_d = 1'b0; usesRm_d = 1'b0;
      Rn_x = 5'd0; Rm_x = 5'd0; destreg_x = 5'd0; MemRead_x = 1'b0;
      destreg_m = 5'd0; RegWrite_m = 1'b0; destreg_w = 5'd0; RegWrite_w = 1'b0;
      br_taken_m = 1'b0; mem_busy = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      RegWrite_m = 1'b1; destreg_m = 5'd4; Rn_x = 5'd4;
      #13;
      tests_run++;
      if (ctl !== V_RUN) begin
         tests_failed++;
         $display("FAIL reset_ctl: got %b expected %b", ctl, V_RUN);
      end
      tests_run++;
      if ({fwdA, fwdB, stall_cnt, flush_cnt} !== {4'b0000, {CW{1'b0}}, {CW{1'b0}}}) begin
         tests_failed++;
         $display("FAIL reset_fwd_cnt: got fwd=%b%b st=%0d fl=%0d expected 0", fwdA, fwdB, stall_cnt, flush_cnt);
      end
      idle_inputs();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_forwarding();
      logic [4:0] v_m [4];
      logic [4:0] v_w [4];
      logic [4:0] v_n [4];
      logic [4:0] v_r [4];
      logic       e_m [4];
      logic       e_w [4];
      logic [3:0] e_f [4];
      v_m = '{5'd3, 5'd3, 5'd3, 5'd31};
      v_w = '{5'd3, 5'd3, 5'd7, 5'd31};
      v_n = '{5'd3, 5'd3, 5'd3, 5'd31};
      v_r = '{5'd3, 5'd3, 5'd7, 5'd31};
      e_m = '{1'b1, 1'b0, 1'b1, 1'b1};
      e_w = '{1'b1, 1'b1, 1'b1, 1'b1};
      e_f = '{4'b0101, 4'b1010, 4'b0110, 4'b0000};
      for (int i = 0; i < 4; i++) begin
         destreg_m = v_m[i]; RegWrite_m = e_m[i];
         destreg_w = v_w[i]; RegWrite_w = e_w[i];
         Rn_x = v_n[i]; Rm_x = v_r[i];
         #2;
         tests_run++;
         if ({fwdA, fwdB} !== e_f[i]) begin
            tests_failed++;
            $display("FAIL fwd_%0d: got %b expected %b", i, {fwdA, fwdB}, e_f[i]);
         end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_load_use();
      // Rn path stalls, then the bubble clears MemRead_x
      MemRead_x = 1'b1; destreg_x = 5'd5; usesRn_d = 1'b1; Rn_d = 5'd5;
      #2;
      tests_run++;
      if (ctl !== V_STALL) begin
         tests_failed++;
         $display("FAIL lu_rn_stall: got %b expected %b", ctl, V_STALL);
      end
      tick(); e_stall++;
      MemRead_x = 1'b0;
      #2;
      tests_run++;
      if (ctl !== V_RUN || stall_cnt !== cexp(e_stall)) begin
         tests_failed++;
         $display("FAIL lu_rn_after: got ctl=%b st=%0d expected %b st=%0d", ctl, stall_cnt, V_RUN, cexp(e_stall));
      end
      tick();
      // XZR destination never stalls
      MemRead_x = 1'b1; destreg_x = 5'd31; Rn_d = 5'd31;
      #2;
      tests_run++;
      if (ctl !== V_RUN) begin
         tests_failed++;
         $display("FAIL lu_xzr: got %b expected %b", ctl, V_RUN);
      end
      tick();
      // Rm path, and a match on an unused source does not stall
      usesRn_d = 1'b0; Rn_d = 5'd9; Rm_d = 5'd9; destreg_x = 5'd9; usesRm_d = 1'b1;
      #2;
      tests_run++;
      if (ctl !== V_STALL) begin
         tests_failed++;
         $display("FAIL lu_rm_stall: got %b expected %b", ctl, V_STALL);
      end
      tick(); e_stall++;
      usesRm_d = 1'b0;
      #2;
      tests_run++;
      if (ctl !== V_RUN || stall_cnt !== cexp(e_stall)) begin
         tests_failed++;
         $display("FAIL lu_unused_src: got ctl=%b st=%0d expected %b st=%0d", ctl, stall_cnt, V_RUN, cexp(e_stall));
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_branch_flush();
      logic [5:0] exp_v [4];
      exp_v = '{V_BR, V_FL, V_FL, V_RUN};
      // A pending load-use is ignored both in the branch cycle and inside the window
      MemRead_x = 1'b1; destreg_x = 5'd6; usesRn_d = 1'b1; Rn_d = 5'd6;
      for (int c = 0; c < 4; c++) begin
         br_taken_m = (c == 0);
         if (c == 3) MemRead_x = 1'b0;
         #2;
         tests_run++;
         if (ctl !== exp_v[c]) begin
            tests_failed++;
            $display("FAIL branch_cycle%0d: got %b expected %b", c, ctl, exp_v[c]);
         end
         tick();
         if (c == 0) e_flush++;
      end
      tests_run++;
      if (flush_cnt !== cexp(e_flush) || stall_cnt !== cexp(e_stall)) begin
         tests_failed++;
         $display("FAIL branch_cnt: got fl=%0d st=%0d expected fl=%0d st=%0d", flush_cnt, stall_cnt, cexp(e_flush), cexp(e_stall));
      end
      idle_inputs();
   endtask

   task automatic test_busy_branch();
      logic [5:0] exp_v [6];
      exp_v = '{V_HOLD, V_HOLD, V_HOLD, V_BR, V_FL, V_FL};
      br_taken_m = 1'b1;
      for (int c = 0; c < 6; c++) begin
         mem_busy = (c < 3);
         if (c >= 4) br_taken_m = 1'b0;
         #2;
         tests_run++;
         if (ctl !== exp_v[c]) begin
            tests_failed++;
            $display("FAIL busy_br_cycle%0d: got %b expected %b", c, ctl, exp_v[c]);
         end
         tick();
         if (c < 3) e_stall++;
         if (c == 2) begin
            tests_run++;
            if (stall_cnt !== cexp(e_stall) || flush_cnt !== cexp(e_flush)) begin
               tests_failed++;
               $display("FAIL busy_br_hold_cnt: got st=%0d fl=%0d expected st=%0d fl=%0d", stall_cnt, flush_cnt, cexp(e_stall), cexp(e_flush));
            end
         end
         if (c == 3) e_flush++;
      end
      #2;
      tests_run++;
      if (ctl !== V_RUN || flush_cnt !== cexp(e_flush)) begin
         tests_failed++;
         $display("FAIL busy_br_end: got ctl=%b fl=%0d expected %b fl=%0d", ctl, flush_cnt, V_RUN, cexp(e_flush));
      end
      idle_inputs();
   endtask

   task automatic test_busy_in_flush();
      logic [5:0] exp_v [5];
      exp_v = '{V_BR, V_HOLD, V_FL, V_FL, V_RUN};
      for (int c = 0; c < 5; c++) begin
         br_taken_m = (c == 0);
         mem_busy = (c == 1);
         #2;
         tests_run++;
         if (ctl !== exp_v[c]) begin
            tests_failed++;
            $display("FAIL busy_flush_cycle%0d: got %b expected %b", c, ctl, exp_v[c]);
         end
         tick();
         if (c == 0) e_flush++;
         if (c == 1) e_stall++;
      end
      tests_run++;
      if (stall_cnt !== cexp(e_stall) || flush_cnt !== cexp(e_flush)) begin
         tests_failed++;
         $display("FAIL busy_flush_cnt: got st=%0d fl=%0d expected st=%0d fl=%0d", stall_cnt, flush_cnt, cexp(e_stall), cexp(e_flush));
      end
      idle_inputs();
   endtask

   task automatic test_saturation();
      mem_busy = 1'b1;
      for (int c = 0; c < (1 << CW) + 5; c++) begin
         tick();
         e_stall++;
      end
      mem_busy = 1'b0;
      #2;
      tests_run++;
      if (stall_cnt !== cexp(e_stall) || flush_cnt !== cexp(e_flush)) begin
         tests_failed++;
         $display("FAIL saturate: got st=%0d fl=%0d expected st=%0d fl=%0d", stall_cnt, flush_cnt, cexp(e_stall), cexp(e_flush));
      end
      tick();
   endtask

   task automatic test_reset_mid_flush();
      br_taken_m = 1'b1;
      tick();
      br_taken_m = 1'b0;
      tick();
      // window now has one cycle left
      #2;
      tests_run++;
      if (ctl !== V_FL) begin
         tests_failed++;
         $display("FAIL rst_flush_pre: got %b expected %b", ctl, V_FL);
      end
      reset = 1'b1;
      e_stall = 0;
      e_flush = 0;
      #1;
      tests_run++;
      if (ctl !== V_RUN || stall_cnt !== '0 || flush_cnt !== '0) begin
         tests_failed++;
         $display("FAIL rst_flush_abort: got ctl=%b st=%0d fl=%0d expected %b 0 0", ctl, stall_cnt, flush_cnt, V_RUN);
      end
      tick();
      reset = 1'b0;
      tick();
      #2;
      tests_run++;
      if (ctl !== V_RUN) begin
         tests_failed++;
         $display("FAIL rst_flush_run: got %b expected %b", ctl, V_RUN);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_forwarding();
      test_load_use();
      test_branch_flush();
      test_busy_branch();
      test_busy_in_flush();
      test_saturation();
      test_reset_mid_flush();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Backward-facing control block for the 5-stage pipeline.
- Consumes fields already latched in the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers.
- Drives enable, bubble and flush controls back into those registers and into the PC.
- Also produces the EX-stage operand forwarding selects. Owns the load-use stall, taken-branch flush window, and memory-busy freeze.

Parameters:
- FLUSH_CYCLES, 1: extra cycles ifde_flush stays high after a taken branch (1..15).
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- Rn_d  in  5  Rn of instruction in IF/ID
- Rm_d  in  5  Rm of instruction in IF/ID
- usesRn_d  in  1  IF/ID instruction reads Rn
- usesRm_d  in  1  IF/ID instruction reads Rm
- Rn_x  in  5  Rn held in ID/EX
- Rm_x  in  5  Rm held in ID/EX
- destreg_x  in  5  destination held in ID/EX
- MemRead_x  in  1  ID/EX instruction is a load
- destreg_m  in  5  destination held in EX/MEM
- RegWrite_m  in  1  EX/MEM writes a register
- destreg_w  in  5  destination held in MEM/WB
- RegWrite_w  in  1  MEM/WB writes a register
- br_taken_m  in  1  branch in MEM resolved taken
- mem_busy  in  1  data memory not ready; MEM cannot complete
- pc_en  out  1  PC update enable
- ifde_en  out  1  IF/ID load enable
- ifde_flush  out  1  IF/ID loads zeros (NOP)
- idex_bubble  out  1  ID/EX loads zeroed control
- exmem_flush  out  1  EX/MEM loads zeroed control
- all_hold  out  1  every stage register holds
- fwdA  out  2  EX operand A select: 00 regfile, 01 EX/MEM, 10 MEM/WB
- fwdB  out  2  EX operand B select, same encoding
- stall_cnt  out  CNT_W  load-use + busy stall cycles
- flush_cnt  out  CNT_W  taken-branch events

Behaviour:
- Reset (async, immediate):
  - state=RUN, flush counter=0, stall_cnt=0, flush_cnt=0.
  - Outputs: pc_en=1, ifde_en=1, all flush/bubble/hold outputs 0, fwdA=fwdB=00.
- Register 31 (XZR) never matches any hazard or forwarding comparison.
- Forwarding (combinational, every cycle, independent of state):
  - fwdA=01 if RegWrite_m && destreg_m==Rn_x.
  - else fwdA=10 if RegWrite_w && destreg_w==Rn_x.
  - else 00. EX/MEM has priority over MEM/WB.
  - fwdB uses the same rules against Rm_x.
- Load-use (lu) = MemRead_x && ((usesRn_d && Rn_d==destreg_x) || (usesRm_d && Rm_d==destreg_x)).
- FSM states: RUN, FLUSH. Priority within any cycle: mem_busy > br_taken_m > lu.
- mem_busy=1 (any state):
  - all_hold=1, pc_en=0, ifde_en=0, no flush/bubble.
  - FSM and flush counter frozen; stall_cnt +1.
  - A br_taken_m arriving during busy is acted on in the first cycle busy is low (input stays asserted because EX/MEM holds).
- RUN, br_taken_m=1:
  - ifde_flush=1, idex_bubble=1, exmem_flush=1, pc_en=1; flush_cnt +1.
  - Load counter with FLUSH_CYCLES; next state FLUSH. lu is ignored this cycle.
- RUN, lu=1:
  - pc_en=0, ifde_en=0, idex_bubble=1; stall_cnt +1.
  - Exactly one bubble per load-use: the bubble clears MemRead_x next cycle.
- RUN, otherwise: all enables 1, no flush.
- FLUSH:
  - ifde_flush=1, pc_en=1; decrement counter; return to RUN when counter reaches 1→0.
  - lu is ignored in FLUSH (IF/ID is squashed).
  - A second br_taken_m in FLUSH is impossible (younger ops already bubbled) and is ignored.
- Counters saturate at all-ones; no wrap.
- Reset mid-FLUSH aborts the window immediately.

Optional Feature:
- PERF_CNT_EN defined: stall_cnt/flush_cnt implemented as above.
- Undefined: no counter flops; both outputs tied to 0. All other behaviour identical.

Test Plan:
- Reset high mid-FLUSH (counter=1) → same cycle pc_en=1, ifde_flush=0, stall_cnt=0; RUN after release.
- MemRead_x=1, destreg_x=5, usesRn_d=1, Rn_d=5 → one cycle pc_en=0, ifde_en=0, idex_bubble=1, stall_cnt 0→1; next cycle (MemRead_x=0) normal. Same stimulus with destreg_x=31 → no stall.
- RegWrite_m=1, destreg_m=3, RegWrite_w=1, destreg_w=3, Rn_x=3, Rm_x=3 → fwdA=01, fwdB=01. Drop RegWrite_m → both 10.
- FLUSH_CYCLES=2, br_taken_m pulse → cycle0 all three flushes; cycles1–2 ifde_flush only; cycle3 clear; flush_cnt=1.
- mem_busy=1 for 3 cycles with br_taken_m=1 → all_hold=1 three cycles, stall_cnt=3, no flush; cycle 4 flush fires, flush_cnt=1.
- With PERF_CNT_EN: force 2^CNT_W+5 stall cycles → stall_cnt holds all-ones. Without macro → counters always 0.
